uart_rx_monitor: RTL and testbench
==================================

UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 Parameter DIV, default 868, clocks per bit (XCLK/baud); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, at least 2.
REQ-003 XCLK  input  1  sole clock; all logic rising-edge.
REQ-004 XRES  input  1  reset, synchronous, active-high.
REQ-005 UART_RXD  input  1  serial line from the SoC UART_TXD; asynchronous, idle high, 8N1, LSB first.
REQ-006 RX_DATA  output  8  head-of-FIFO byte; valid only while RX_VALID=1.
REQ-007 RX_VALID  output  1  FIFO non-empty.
REQ-008 RX_READY  input  1  consumer accepts head byte when RX_VALID&RX_READY.
REQ-009 FRAME_ERR  output  1  one-cycle pulse on a bad stop bit.
REQ-010 OVERFLOW  output  1  sticky; a byte was dropped because the FIFO was full.
REQ-011 BUSY  output  1  receive FSM not in IDLE.

Function
REQ-012 UART_RXD shall pass through a 2-flop synchronizer, reset to 1; the FSM uses only the synchronized value.
REQ-013 FSM states shall be IDLE, START, DATA, STOP, and WAIT_IDLE.
REQ-014 IDLE: a synchronized 0 shall load the baud counter and enter START.
REQ-015 START: after DIV/2 cycles, sample the line; 0 enters DATA; 1 is a false start and returns to IDLE with no output.
REQ-016 DATA: every DIV cycles, sample one bit into the shift register, LSB first; after the 8th sample, enter STOP.
REQ-017 STOP: after DIV cycles, sample the line; 1 pushes the byte to the FIFO and enters IDLE.
REQ-018 STOP: a sampled 0 discards the byte, pulses FRAME_ERR for exactly one cycle, and enters WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until the synchronized line is 1, then enter IDLE; a new start bit is never accepted while the line is still low.
REQ-020 Baud counter width shall be $clog2(DIV); it reloads on every state entry and never wraps mid-bit.
REQ-021 Push latency: RX_VALID shall rise on the cycle after the stop-bit sample when the FIFO was empty.
REQ-022 FIFO is first-word-fallthrough: RX_DATA reflects the head entry combinationally from the FIFO registers.
REQ-023 Pop occurs on a cycle with RX_VALID&RX_READY; RX_READY while RX_VALID=0 shall be ignored.
REQ-024 Simultaneous push and pop shall both succeed, including when the FIFO is full; occupancy is unchanged.
REQ-025 Push while full without a same-cycle pop shall drop the new byte, keep the stored contents, and set OVERFLOW.
REQ-026 Read and write pointers shall wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
REQ-027 Back-to-back frames with no idle gap beyond the stop bit shall be received without loss.

Reset
REQ-028 While XRES=1, the FSM enters IDLE and the FIFO pointers clear.
REQ-029 While XRES=1, RX_VALID=0, FRAME_ERR=0, OVERFLOW=0, BUSY=0, and RX_DATA=0x00.
REQ-030 While XRES=1, the synchronizer flops are set to 1 and the counters and shift register clear.
REQ-031 Reset asserted mid-frame shall abandon the partial byte; the next complete frame after release shall be received correctly.

Structure
REQ-032 Shared package uart_pkg shall hold the FSM state enum, the default DIV constant, and the frame length constant (8).
REQ-033 The FIFO shall be a separate sub-module uart_rx_fifo (parameters WIDTH, DEPTH) carrying the push/pop/full/empty logic; uart_rx_monitor holds the synchronizer, FSM, and shift register.

Verification (DIV=16, FIFO_DEPTH=4)
REQ-034 Drive frame 0x55, RX_READY=1 -> RX_VALID pulses once with RX_DATA=0x55; FRAME_ERR=0 and OVERFLOW=0 throughout.
REQ-035 Drive a 4-cycle low glitch on an idle line -> BUSY rises then falls within 12 cycles; no RX_VALID, no FRAME_ERR.
REQ-036 Drive frame 0xA5 with a 0 stop bit, then hold the line high -> one FRAME_ERR pulse, FIFO stays empty, FSM returns to IDLE; a following 0x3C is received correctly.
REQ-037 Drive 0x01..0x05 back-to-back with RX_READY=0, then raise RX_READY -> reads 0x01,0x02,0x03,0x04 in order; OVERFLOW=1 stays set; 0x05 is absent.
REQ-038 Pulse XRES for 1 cycle during data bit 3 of 0xFF -> all outputs are 0 on the next cycle; a subsequent 0x81 yields exactly one byte, 0x81.
REQ-039 Hold the FIFO full with RX_READY=1 asserted on the same cycle as the stop-bit push -> no OVERFLOW; occupancy stays 4; order is preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive monitor.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int DIV_DEFAULT = 868;
    localparam int FRAME_BITS  = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fallthrough receive FIFO with an extra pointer bit
// to tell full from empty.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop frees the slot in the same cycle, so a full FIFO still
    // accepts a push when the head is being consumed.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: line synchronizer, receive FSM and shift
// register feeding a small FWFT FIFO.
module uart_rx_monitor
    import uart_pkg::*;
#(
    parameter int DIV        = DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       XCLK,
    input  logic       XRES,
    input  logic       UART_RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERFLOW,
    output logic       BUSY
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(FRAME_BITS - 1);

    rx_state_t state, state_n;
    logic [1:0]    sync;
    logic          rxd_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          push;
    logic          ferr_n;
    logic          tick;
    logic          empty;
    logic          full;
    logic          drop;

    assign rxd_s = sync[1];
    assign tick  = (cnt == '0);

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            FRAME_ERR <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            sync      <= {sync[0], UART_RXD};
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shreg     <= sh_n;
            FRAME_ERR <= ferr_n;
            OVERFLOW  <= OVERFLOW | drop;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        push    = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_n = START;
                    cnt_n   = HALF_BIT;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else if (!rxd_s) begin
                    state_n = DATA;
                    cnt_n   = FULL_BIT;
                    bit_n   = '0;
                end else begin
                    state_n = IDLE;
                    cnt_n   = FULL_BIT;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    sh_n  = {rxd_s, shreg[7:1]};
                    cnt_n = FULL_BIT;
                    bit_n = bit_idx + 3'd1;
                    if (bit_idx == LAST_BIT) state_n = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n = FULL_BIT;
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_n = IDLE;
                    cnt_n   = FULL_BIT;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign RX_VALID = ~empty;
    assign BUSY     = (state != IDLE);

    uart_rx_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (XCLK),
        .rst  (XRES),
        .push (push),
        .wdata(shreg),
        .pop  (RX_VALID & RX_READY),
        .rdata(RX_DATA),
        .full (full),
        .empty(empty),
        .drop (drop)
    );

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor at DIV=16, FIFO_DEPTH=4.
module tb_uart_rx_monitor;

    localparam int DIV = 16;

    logic       XCLK = 1'b0;
    logic       XRES = 1'b1;
    logic       UART_RXD = 1'b1;
    logic       RX_READY = 1'b0;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       OVERFLOW;
    logic       BUSY;

    int tests = 0;
    int fails = 0;

    logic [7:0] rxq[$];
    int fe_cnt;
    int valid_cycles;
    int ovf_seen;
    int busy_seen;

    uart_rx_monitor #(
        .DIV(DIV),
        .FIFO_DEPTH(4)
    ) dut (
        .XCLK     (XCLK),
        .XRES     (XRES),
        .UART_RXD (UART_RXD),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .RX_READY (RX_READY),
        .FRAME_ERR(FRAME_ERR),
        .OVERFLOW (OVERFLOW),
        .BUSY     (BUSY)
    );

    always #5 XCLK = ~XCLK;

    always @(negedge XCLK) begin
        if (!XRES) begin
            if (RX_VALID && RX_READY) rxq.push_back(RX_DATA);
            if (FRAME_ERR) fe_cnt++;
            if (RX_VALID) valid_cycles++;
            if (OVERFLOW) ovf_seen = 1;
            if (BUSY) busy_seen = 1;
        end
    end

    task automatic clear_mon();
        rxq.delete();
        fe_cnt = 0;
        valid_cycles = 0;
        ovf_seen = 0;
        busy_seen = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge XCLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        UART_RXD = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = d[i];
            wait_cycles(DIV);
        end
        UART_RXD = stop;
        wait_cycles(DIV);
        UART_RXD = 1'b1;
    endtask

    task automatic test_reset();
        XRES = 1'b1;
        UART_RXD = 1'b1;
        wait_cycles(3);
        tests++;
        if (RX_VALID !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid got=%b exp=0", RX_VALID);
        end
        tests++;
        if (FRAME_ERR !== 1'b0) begin
            fails++;
            $display("FAIL reset_ferr got=%b exp=0", FRAME_ERR);
        end
        tests++;
        if (OVERFLOW !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf got=%b exp=0", OVERFLOW);
        end
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got=%b exp=0", BUSY);
        end
        tests++;
        if (RX_DATA !== 8'h00) begin
            fails++;
            $display("FAIL reset_data got=%h exp=00", RX_DATA);
        end
        XRES = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_single();
        RX_READY = 1'b1;
        clear_mon();
        send_byte(8'h55, 1'b1);
        wait_cycles(30);
        tests++;
        if (rxq.size() !== 1) begin
            fails++;
            $display("FAIL single_count got=%0d exp=1", rxq.size());
        end
        tests++;
        if ((rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'h55) begin
            fails++;
            $display("FAIL single_data got=%h exp=55",
                     rxq.size() > 0 ? rxq[0] : 8'hxx);
        end
        tests++;
        if (valid_cycles !== 1) begin
            fails++;
            $display("FAIL single_valid_cycles got=%0d exp=1",
                     valid_cycles);
        end
        tests++;
        if (fe_cnt !== 0 || ovf_seen !== 0) begin
            fails++;
            $display("FAIL single_flags got=fe%0d/ovf%0d exp=0/0",
                     fe_cnt, ovf_seen);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        UART_RXD = 1'b0;
        wait_cycles(4);
        tests++;
        if (BUSY !== 1'b1) begin
            fails++;
            $display("FAIL glitch_busy_rise got=%b exp=1", BUSY);
        end
        UART_RXD = 1'b1;
        wait_cycles(8);
        tests++;
        if (BUSY !== 1'b0 || busy_seen !== 1) begin
            fails++;
            $display("FAIL glitch_busy_fall got=%b/%0d exp=0/1",
                     BUSY, busy_seen);
        end
        wait_cycles(20);
        tests++;
        if (valid_cycles !== 0 || fe_cnt !== 0) begin
            fails++;
            $display("FAIL glitch_no_output got=v%0d/fe%0d exp=0/0",
                     valid_cycles, fe_cnt);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_byte(8'hA5, 1'b0);
        wait_cycles(10);
        tests++;
        if (fe_cnt !== 1) begin
            fails++;
            $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt);
        end
        tests++;
        if (valid_cycles !== 0 || RX_VALID !== 1'b0) begin
            fails++;
            $display("FAIL ferr_fifo_empty got=%0d/%b exp=0/0",
                     valid_cycles, RX_VALID);
        end
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("FAIL ferr_idle got=%b exp=0", BUSY);
        end
        clear_mon();
        send_byte(8'h3C, 1'b1);
        wait_cycles(30);
        tests++;
        if (rxq.size() !== 1 ||
            (rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'h3C) begin
            fails++;
            $display("FAIL ferr_recover got=n%0d/%h exp=n1/3c",
                     rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
        end
    endtask

    task automatic test_overflow();
        RX_READY = 1'b0;
        clear_mon();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        wait_cycles(20);
        tests++;
        if (OVERFLOW !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set got=%b exp=1", OVERFLOW);
        end
        RX_READY = 1'b1;
        wait_cycles(10);
        RX_READY = 1'b0;
        tests++;
        if (rxq.size() !== 4) begin
            fails++;
            $display("FAIL ovf_count got=%0d exp=4", rxq.size());
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ((rxq.size() > i ? rxq[i] : 8'hxx) !== 8'(i + 1)) begin
                fails++;
                $display("FAIL ovf_order[%0d] got=%h exp=%h", i,
                         rxq.size() > i ? rxq[i] : 8'hxx, 8'(i + 1));
            end
        end
        tests++;
        if (OVERFLOW !== 1'b1 || RX_VALID !== 1'b0) begin
            fails++;
            $display("FAIL ovf_sticky got=ovf%b/v%b exp=1/0",
                     OVERFLOW, RX_VALID);
        end
    endtask

    task automatic test_reset_midframe();
        RX_READY = 1'b1;
        clear_mon();
        UART_RXD = 1'b0;
        wait_cycles(DIV);
        UART_RXD = 1'b1;
        wait_cycles(3 * DIV + DIV / 2);
        XRES = 1'b1;
        wait_cycles(1);
        XRES = 1'b0;
        tests++;
        if ({RX_VALID, FRAME_ERR, OVERFLOW, BUSY} !== 4'b0000 ||
            RX_DATA !== 8'h00) begin
            fails++;
            $display("FAIL midrst_outputs got=%b%b%b%b/%h exp=0000/00",
                     RX_VALID, FRAME_ERR, OVERFLOW, BUSY, RX_DATA);
        end
        wait_cycles(7 * DIV);
        send_byte(8'h81, 1'b1);
        wait_cycles(30);
        tests++;
        if (rxq.size() !== 1 ||
            (rxq.size() > 0 ? rxq[0] : 8'hxx) !== 8'h81) begin
            fails++;
            $display("FAIL midrst_next got=n%0d/%h exp=n1/81",
                     rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
        end
        tests++;
        if (fe_cnt !== 0) begin
            fails++;
            $display("FAIL midrst_ferr got=%0d exp=0", fe_cnt);
        end
    endtask

    task automatic test_full_push_pop();
        RX_READY = 1'b0;
        clear_mon();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        // Stop-bit sample of a frame lands 155 edges after its start.
        fork
            send_byte(8'h05, 1'b1);
            begin
                wait_cycles(154);
                RX_READY = 1'b1;
                wait_cycles(1);
                RX_READY = 1'b0;
            end
        join
        wait_cycles(5);
        tests++;
        if (OVERFLOW !== 1'b0 || RX_VALID !== 1'b1) begin
            fails++;
            $display("FAIL fullpp_state got=ovf%b/v%b exp=0/1",
                     OVERFLOW, RX_VALID);
        end
        RX_READY = 1'b1;
        wait_cycles(10);
        RX_READY = 1'b0;
        tests++;
        if (rxq.size() !== 5) begin
            fails++;
            $display("FAIL fullpp_count got=%0d exp=5", rxq.size());
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ((rxq.size() > i ? rxq[i] : 8'hxx) !== 8'(i + 1)) begin
                fails++;
                $display("FAIL fullpp_order[%0d] got=%h exp=%h", i,
                         rxq.size() > i ? rxq[i] : 8'hxx, 8'(i + 1));
            end
        end
        tests++;
        if (ovf_seen !== 0) begin
            fails++;
            $display("FAIL fullpp_no_ovf got=%0d exp=0", ovf_seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_reset_midframe();
        test_full_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
